// File: rtl/tdc_therm_encoder.sv
// Thermometer-to-binary fine-time encoder: 2-flop sync, rising-edge hit detect,
// optional majority bubble correction (TDC_BUBBLE_CORR_EN), popcount, valid/ready output.
module tdc_therm_encoder #(
  parameter int N  = 32,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*4-1:0]    therm,
  output logic [CW-1:0]     out_code,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        drop_cnt
);
  localparam int W = N * 4;

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] r_s1;
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] r_s2;
  logic          r_s2_b0_d;
  logic [CW-1:0] r_cnt;
  logic          r_cnt_v;

  logic          w_hit;
  logic [W-1:0]  w_corr;
  logic [CW-1:0] w_pop;

  assign w_hit = r_s2[0] & ~r_s2_b0_d;

`ifdef TDC_BUBBLE_CORR_EN
  // Pad below with 1 (start side) and above with 0 so the chain ends are stable.
  logic [W+1:0] w_ext;
  assign w_ext = {1'b0, r_s2, 1'b1};
  for (genvar g = 0; g < W; g++) begin : g_maj
    assign w_corr[g] = (w_ext[g] & w_ext[g+1]) | (w_ext[g] & w_ext[g+2]) |
                       (w_ext[g+1] & w_ext[g+2]);
  end
`else
  assign w_corr = r_s2;
`endif

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++) w_pop = w_pop + CW'(w_corr[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_s2_b0_d <= 1'b0;
      r_cnt     <= '0;
      r_cnt_v   <= 1'b0;
    end else begin
      r_s1      <= therm;
      r_s2      <= r_s1;
      r_s2_b0_d <= r_s2[0];
      r_cnt_v   <= w_hit;
      if (w_hit) r_cnt <= w_pop;
    end
  end

  // A new code may replace the held one only when the slot is empty or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_code  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (r_cnt_v && (!out_valid || out_ready)) begin
        out_code  <= r_cnt;
        out_sat   <= (r_cnt == CW'(W));
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (r_cnt_v && out_valid && !out_ready && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tdc_therm_encoder.sv
// Bench for tdc_therm_encoder: event-queue model checked every cycle plus directed literal checks.
module tb_tdc_therm_encoder;
  localparam int N  = 32;
  localparam int CW = 8;
  localparam int W  = N * 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  therm = '0;
  logic [CW-1:0] out_code;
  logic          out_sat;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  tdc_therm_encoder #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .therm(therm), .out_code(out_code),
    .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ones(input int n);
    logic [W-1:0] m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Expected code of a sampled word, straight from the correction rule.
  function automatic int model_code(input logic [W-1:0] w);
    int n = 0;
    for (int i = 0; i < W; i++) begin
`ifdef TDC_BUBBLE_CORR_EN
      int lo, hi;
      lo = (i == 0) ? 1 : int'(w[i-1]);
      hi = (i == W-1) ? 0 : int'(w[i+1]);
      if (lo + int'(w[i]) + hi >= 2) n++;
`else
      if (w[i]) n++;
`endif
    end
    return n;
  endfunction

  // Model: each hit becomes an event due at the output three edges after sampling.
  typedef struct { int due; int code; } ev_t;
  ev_t  q[$];
  int   cyc = 0;
  logic prev_b0 = 1'b0;
  logic m_valid = 1'b0;
  int   m_code = 0;
  logic m_sat = 1'b0;
  int   m_drop = 0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      prev_b0 = 1'b0; m_valid = 1'b0; m_code = 0; m_sat = 1'b0; m_drop = 0;
    end else begin
      logic [W-1:0] w;
      logic rdy, offer, vold;
      int oc;
      w = therm; rdy = out_ready;
      cyc++;
      offer = 1'b0; oc = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        offer = 1'b1; oc = q[0].code; void'(q.pop_front());
      end
      vold = m_valid;
      if (offer && (!vold || rdy)) begin
        m_valid = 1'b1; m_code = oc; m_sat = (oc == W);
      end else if (vold && rdy) begin
        m_valid = 1'b0;
      end
      if (offer && vold && !rdy && m_drop < 255) m_drop++;
      if (w[0] && !prev_b0) q.push_back('{cyc + 3, model_code(w)});
      prev_b0 = w[0];
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_code", int'(out_code), 0);
      chk("rst_drop", int'(drop_cnt), 0);
    end else begin
      chk("m_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        chk("m_code", int'(out_code), m_code);
        chk("m_sat", int'(out_sat), int'(m_sat));
      end
      chk("m_drop", int'(drop_cnt), m_drop);
    end
  end

  // Drive a word for `hold` cycles, then observe `ncyc` negedges.
  task automatic pulse_obs(input logic [W-1:0] word, input int hold, input int ncyc,
                           output int nvalid, output int first, output int code, output int sat);
    nvalid = 0; first = -1; code = -1; sat = -1;
    @(negedge clk); therm = word; out_ready = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (out_valid) begin
        nvalid++;
        if (first < 0) begin first = i; code = int'(out_code); sat = int'(out_sat); end
      end
      if (i == hold) therm = '0;
    end
  endtask

  int nv, fi, cd, st;
  logic [W-1:0] bw;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_sat", int'(out_sat), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    pulse_obs(ones(37), 1, 6, nv, fi, cd, st);
    chk("clean_count", nv, 1); chk("clean_lat", fi, 4);
    chk("clean_code", cd, 37); chk("clean_sat", st, 0);

    bw = ones(20); bw[10] = 1'b0;
    pulse_obs(bw, 1, 6, nv, fi, cd, st);
`ifdef TDC_BUBBLE_CORR_EN
    chk("bubble_code", cd, 20);
`else
    chk("bubble_code", cd, 19);
`endif
    chk("bubble_count", nv, 1);

    pulse_obs(ones(W), 1, 6, nv, fi, cd, st);
    chk("sat_code", cd, 128); chk("sat_flag", st, 1);

    pulse_obs(ones(1), 10, 16, nv, fi, cd, st);
    chk("held_count", nv, 1); chk("held_code", cd, 1);

    // Backpressure: three hits while the consumer stalls.
    @(negedge clk); out_ready = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk); therm = ones(k);
      @(negedge clk); therm = '0;
    end
    repeat (4) @(negedge clk);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_code", int'(out_code), 5);
    chk("bp_drop", int'(drop_cnt), 2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", int'(out_valid), 0);

    // Mixed traffic: back-to-back hits with a toggling consumer.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      therm = (i % 2 == 0) ? ones(3 * i + 1) : '0;
      out_ready = (i % 5 != 3);
    end
    @(negedge clk); therm = '0; out_ready = 1'b1;
    repeat (5) @(negedge clk);

    // Reset one cycle after a hit is sampled.
    @(negedge clk); therm = ones(50);
    @(negedge clk); therm = '0;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("rstmid_count", nv, 0);
    chk("rstmid_code", int'(out_code), 0);
    chk("rstmid_sat", int'(out_sat), 0);
    chk("rstmid_drop", int'(drop_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
